// File: rtl/bitstream_serializer.sv
// Parallel-to-serial feeder: buffers WIDTH-bit words in a small FIFO and emits
// them one bit per clock on x, with no idle bit between back-to-back words.
module bitstream_serializer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             x_q, x_d, x_valid_q, x_valid_d, x_last_q, x_last_d;
    logic             push, pop;

    assign in_ready = (count_q != FULL);
    assign push     = in_valid && in_ready;
    assign busy     = (count_q != '0) || (state_q == SHIFT);
    assign x        = x_q;
    assign x_valid  = x_valid_q;
    assign x_last   = x_last_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hold && count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // x_valid_q marks that the current bit was presented last cycle,
                // so the shifter only advances past bits actually emitted.
                if (x_valid_q) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (count_q != '0) begin
                            pop       = 1'b1;
                            shift_d   = mem_q[rd_ptr_q];
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shift_d   = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        x_valid_d = (state_d == SHIFT) && !hold;
        x_d       = x_valid_d && ((MSB_FIRST != 0) ? shift_d[WIDTH-1] : shift_d[0]);
        x_last_d  = x_valid_d && (bit_cnt_d == LAST_BIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            x_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            x_last_q  <= x_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end
endmodule

// File: tb/tb_bitstream_serializer.sv
// Drives an MSB-first and an LSB-first serializer with identical stimulus and
// compares both against a queue-based model of the word stream.
module tb_bitstream_serializer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, hold;
    logic       rdy_m, x_m, xv_m, xl_m, busy_m;
    logic       rdy_l, x_l, xv_l, xl_l, busy_l;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bitstream_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
        .hold(hold), .x(x_m), .x_valid(xv_m), .x_last(xl_m), .busy(busy_m));

    bitstream_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
        .hold(hold), .x(x_l), .x_valid(xv_l), .x_last(xl_l), .busy(busy_l));

    // Model: pending words, the word being sent and how many of its bits went out.
    logic [7:0] q[$];
    logic [7:0] cur;
    int         idx;
    bit         active;
    bit         e_v, e_xm, e_xl, e_last, e_busy, e_rdy;

    logic [31:0] cap_m, cap_l;
    int          nvalid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        active = 0; idx = 0; cur = '0;
        e_v = 0; e_xm = 0; e_xl = 0; e_last = 0; e_busy = 0; e_rdy = 1;
    endtask

    task automatic model_step();
        int size0;
        bit was_active, finished;
        size0      = q.size();
        was_active = active;
        finished   = 0;
        if (active && e_v) begin
            idx++;
            if (idx == 8) begin
                active   = 0;
                finished = 1;
            end
        end
        if (size0 > 0 && (finished || (!was_active && !hold))) begin
            cur    = q.pop_front();
            idx    = 0;
            active = 1;
        end
        if (in_valid && size0 < 4) begin
            q.push_back(in_data);
            $display("push word=%02h depth=%0d", in_data, q.size());
        end
        e_v    = active && !hold;
        e_xm   = e_v && cur[7-idx];
        e_xl   = e_v && cur[idx];
        e_last = e_v && (idx == 7);
        e_busy = (q.size() > 0) || active;
        e_rdy  = q.size() < 4;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".x_msb"},   {31'd0, x_m},    {31'd0, e_xm});
        chk({tag, ".x_lsb"},   {31'd0, x_l},    {31'd0, e_xl});
        chk({tag, ".valid_m"}, {31'd0, xv_m},   {31'd0, e_v});
        chk({tag, ".valid_l"}, {31'd0, xv_l},   {31'd0, e_v});
        chk({tag, ".last_m"},  {31'd0, xl_m},   {31'd0, e_last});
        chk({tag, ".last_l"},  {31'd0, xl_l},   {31'd0, e_last});
        chk({tag, ".busy_m"},  {31'd0, busy_m}, {31'd0, e_busy});
        chk({tag, ".busy_l"},  {31'd0, busy_l}, {31'd0, e_busy});
        chk({tag, ".rdy_m"},   {31'd0, rdy_m},  {31'd0, e_rdy});
        chk({tag, ".rdy_l"},   {31'd0, rdy_l},  {31'd0, e_rdy});
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic h);
        in_valid = v;
        in_data  = d;
        hold     = h;
        @(posedge clk);
        model_step();
        #1;
        check_outputs("cyc");
        if (xv_m === 1'b1) begin
            cap_m = {cap_m[30:0], x_m};
            cap_l = {cap_l[30:0], x_l};
            nvalid++;
        end
    endtask

    task automatic clear_cap();
        cap_m = '0; cap_l = '0; nvalid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0);
    endtask

    // Reset is raised between edges so its asynchronous effect is visible.
    task automatic do_reset();
        in_valid = 1'b0;
        hold     = 1'b0;
        rst      = 1'b1;
        #1;
        model_clear();
        check_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("reset applied");
    endtask

    logic [7:0] w [4];

    initial begin
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0; in_data = '0;
        model_clear();
        clear_cap();
        #1;
        check_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word, both bit orders.
        clear_cap();
        cycle(1'b1, 8'hA0, 1'b0);
        chk("single.no_early_bit", {31'd0, xv_m}, 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("single.first_bit_latency", {31'd0, xv_m}, 32'd1);
        idle(8);
        chk("single.msb_bits", cap_m, 32'h0000_00A0);
        chk("single.lsb_bits", cap_l, 32'h0000_0005);
        chk("single.nvalid", nvalid, 8);
        chk("single.busy_end", {31'd0, busy_m}, 32'd0);

        clear_cap();
        cycle(1'b1, 8'h05, 1'b0);
        idle(10);
        chk("lsb05.bits", cap_l[7:0], 32'h0000_00A0);

        // Back-to-back words give 16 contiguous bits.
        clear_cap();
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h40, 1'b0);
        idle(18);
        chk("b2b.bits", cap_m, 32'h0000_0140);
        chk("b2b.nvalid", nvalid, 16);

        // Fill FIFO under hold, then drain in order.
        clear_cap();
        for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) cycle(1'b1, w[i], 1'b1);
        chk("full.ready_low", {31'd0, rdy_m}, 32'd0);
        cycle(1'b1, 8'h3C, 1'b1);
        chk("full.nvalid_held", nvalid, 0);
        idle(40);
        chk("full.order", cap_m, {w[0], w[1], w[2], w[3]});
        chk("full.nvalid", nvalid, 32);

        // Hold mid-word for 3 cycles after bit 3.
        clear_cap();
        cycle(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 20 && nvalid < 3; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("hold.reached_bit3", nvalid, 3);
        repeat (3) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("hold.gap_x", {31'd0, x_m}, 32'd0);
        end
        chk("hold.nvalid_frozen", nvalid, 3);
        idle(10);
        chk("hold.nvalid", nvalid, 8);

        // Reset mid-word with two words queued.
        clear_cap();
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 20 && nvalid < 4; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("rstmid.reached_bit4", nvalid, 4);
        do_reset();
        clear_cap();
        idle(30);
        chk("rstmid.nothing_after", nvalid, 0);

        // Randomized traffic with occasional hold and reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 2) != 0), 8'($urandom),
                      1'($urandom_range(0, 4) == 0));
            end
        end
        idle(50);
        chk("final.idle_busy", {31'd0, busy_m}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
